// File: rtl/rtc_pkg.sv
// Shared calendar constants and helpers for the RTC core and the LCD stage.
package rtc_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_e;

  localparam logic [2:0] FIELD_YEAR  = 3'd0;
  localparam logic [2:0] FIELD_MONTH = 3'd1;
  localparam logic [2:0] FIELD_DAY   = 3'd2;
  localparam logic [2:0] FIELD_HOUR  = 3'd3;
  localparam logic [2:0] FIELD_MIN   = 3'd4;
  localparam logic [2:0] FIELD_SEC   = 3'd5;

  localparam logic [11:0] YEAR_MIN = 12'd2000;
  localparam logic [11:0] YEAR_MAX = 12'd2099;

  localparam logic [11:0] RST_YEAR  = 12'd2024;
  localparam logic [3:0]  RST_MONTH = 4'd1;
  localparam logic [4:0]  RST_DAY   = 5'd1;
  localparam logic [4:0]  RST_HOUR  = 5'd0;
  localparam logic [5:0]  RST_MIN   = 6'd0;
  localparam logic [5:0]  RST_SEC   = 6'd0;

  // year%4 is exact for 2000..2099 (2000 is a leap year)
  function automatic logic [4:0] days_in_month(
    input logic [3:0]  month,
    input logic [11:0] year
  );
    logic [4:0] d;
    case (month)
      4'd2:    d = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      4'd4,
      4'd6,
      4'd9,
      4'd11:   d = 5'd30;
      default: d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and ms-based debouncer.
// Emits a one-cycle pulse on an accepted press; releases are silent.
module btn_debounce #(
  parameter int CNT_MS = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic ms_tick,
  input  logic raw,
  output logic press
);

  localparam int CW = (CNT_MS > 1) ? $clog2(CNT_MS) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // any return to the accepted level restarts the stability window
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (ms_tick) begin
        if (cnt_q == CW'(CNT_MS - 1)) begin
          level_q <= sync2_q;
          press_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/rtc_calendar_set.sv
// Calendar/clock core with button-driven field editing.
// Feeds registered date/time and cursor state to the LCD stage.
module rtc_calendar_set
  import rtc_pkg::*;
#(
  parameter int CNT1MS      = 100_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_MS    = 250
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick1s,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  output logic [11:0] year,
  output logic [3:0]  month,
  output logic [4:0]  day,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic        edit_mode,
  output logic [2:0]  edit_field,
  output logic        blink
);

  localparam int MSW = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
  localparam int BLW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  state_e         state_q;
  logic [11:0]    year_q;
  logic [3:0]     month_q;
  logic [4:0]     day_q;
  logic [4:0]     hour_q;
  logic [5:0]     min_q;
  logic [5:0]     sec_q;
  logic [2:0]     edit_field_q;
  logic           blink_q;
  logic [MSW-1:0] ms_cnt_q;
  logic [BLW-1:0] blink_cnt_q;

  logic ms_tick;
  logic mode_p;
  logic next_p;
  logic up_p;

  logic [4:0] dim_cur;

  logic [11:0] tk_year_d;
  logic [3:0]  tk_month_d;
  logic [4:0]  tk_day_d;
  logic [4:0]  tk_hour_d;
  logic [5:0]  tk_min_d;
  logic [5:0]  tk_sec_d;

  logic [11:0] up_year_d;
  logic [3:0]  up_month_d;
  logic [4:0]  up_day_d;
  logic [4:0]  up_hour_d;
  logic [5:0]  up_min_d;
  logic [5:0]  up_sec_d;
  logic [11:0] yr_inc;
  logic [3:0]  mo_inc;
  logic [4:0]  dim_new;

  assign ms_tick = (ms_cnt_q == MSW'(CNT1MS - 1));
  assign dim_cur = days_in_month(month_q, year_q);
  assign yr_inc  = (year_q == YEAR_MAX) ? YEAR_MIN : year_q + 12'd1;
  assign mo_inc  = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;

  btn_debounce #(.CNT_MS(DEBOUNCE_MS)) u_db_mode (
    .clk    (clk),
    .resetn (resetn),
    .ms_tick(ms_tick),
    .raw    (btn_mode),
    .press  (mode_p)
  );

  btn_debounce #(.CNT_MS(DEBOUNCE_MS)) u_db_next (
    .clk    (clk),
    .resetn (resetn),
    .ms_tick(ms_tick),
    .raw    (btn_next),
    .press  (next_p)
  );

  btn_debounce #(.CNT_MS(DEBOUNCE_MS)) u_db_up (
    .clk    (clk),
    .resetn (resetn),
    .ms_tick(ms_tick),
    .raw    (btn_up),
    .press  (up_p)
  );

  always_comb begin
    tk_year_d  = year_q;
    tk_month_d = month_q;
    tk_day_d   = day_q;
    tk_hour_d  = hour_q;
    tk_min_d   = min_q;
    tk_sec_d   = sec_q;
    if (sec_q != 6'd59) begin
      tk_sec_d = sec_q + 6'd1;
    end else begin
      tk_sec_d = 6'd0;
      if (min_q != 6'd59) begin
        tk_min_d = min_q + 6'd1;
      end else begin
        tk_min_d = 6'd0;
        if (hour_q != 5'd23) begin
          tk_hour_d = hour_q + 5'd1;
        end else begin
          tk_hour_d = 5'd0;
          if (day_q != dim_cur) begin
            tk_day_d = day_q + 5'd1;
          end else begin
            tk_day_d   = 5'd1;
            tk_month_d = mo_inc;
            if (month_q == 4'd12) begin
              tk_year_d = yr_inc;
            end
          end
        end
      end
    end
  end

  always_comb begin
    up_year_d  = year_q;
    up_month_d = month_q;
    up_day_d   = day_q;
    up_hour_d  = hour_q;
    up_min_d   = min_q;
    up_sec_d   = sec_q;
    dim_new    = 5'd31;
    unique case (1'b1)
      (edit_field_q == FIELD_YEAR): begin
        up_year_d = yr_inc;
        dim_new   = days_in_month(month_q, yr_inc);
      end
      (edit_field_q == FIELD_MONTH): begin
        up_month_d = mo_inc;
        dim_new    = days_in_month(mo_inc, year_q);
      end
      (edit_field_q == FIELD_DAY):
        up_day_d = (day_q == dim_cur) ? 5'd1 : day_q + 5'd1;
      (edit_field_q == FIELD_HOUR):
        up_hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      (edit_field_q == FIELD_MIN):
        up_min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      (edit_field_q == FIELD_SEC):
        up_sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      default: ;
    endcase
    // a shorter month after a year/month change pulls the day in
    if (up_day_d > dim_new) begin
      up_day_d = dim_new;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_RUN;
      year_q       <= RST_YEAR;
      month_q      <= RST_MONTH;
      day_q        <= RST_DAY;
      hour_q       <= RST_HOUR;
      min_q        <= RST_MIN;
      sec_q        <= RST_SEC;
      edit_field_q <= FIELD_YEAR;
      blink_q      <= 1'b1;
      ms_cnt_q     <= '0;
      blink_cnt_q  <= '0;
    end else begin
      ms_cnt_q <= ms_tick ? '0 : ms_cnt_q + MSW'(1);
      case (state_q)
        ST_RUN: begin
          if (tick1s) begin
            year_q  <= tk_year_d;
            month_q <= tk_month_d;
            day_q   <= tk_day_d;
            hour_q  <= tk_hour_d;
            min_q   <= tk_min_d;
            sec_q   <= tk_sec_d;
          end
          if (mode_p) begin
            state_q      <= ST_EDIT;
            edit_field_q <= FIELD_YEAR;
            blink_q      <= 1'b1;
            blink_cnt_q  <= '0;
          end
        end
        ST_EDIT: begin
          if (mode_p) begin
            state_q     <= ST_RUN;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
          end else begin
            if (next_p) begin
              edit_field_q <= (edit_field_q == FIELD_SEC) ?
                              FIELD_YEAR : edit_field_q + 3'd1;
            end else if (up_p) begin
              year_q  <= up_year_d;
              month_q <= up_month_d;
              day_q   <= up_day_d;
              hour_q  <= up_hour_d;
              min_q   <= up_min_d;
              sec_q   <= up_sec_d;
            end
            if (ms_tick) begin
              if (blink_cnt_q == BLW'(BLINK_MS - 1)) begin
                blink_q     <= ~blink_q;
                blink_cnt_q <= '0;
              end else begin
                blink_cnt_q <= blink_cnt_q + BLW'(1);
              end
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign year       = year_q;
  assign month      = month_q;
  assign day        = day_q;
  assign hour       = hour_q;
  assign min        = min_q;
  assign sec        = sec_q;
  assign edit_mode  = (state_q == ST_EDIT);
  assign edit_field = edit_field_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_rtc_calendar_set.sv
// Scoreboard bench for rtc_calendar_set with a calendar reference model.
module tb_rtc_calendar_set;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick1s = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_up = 1'b0;
  logic [11:0] o_year;
  logic [3:0]  o_month;
  logic [4:0]  o_day;
  logic [4:0]  o_hour;
  logic [5:0]  o_min;
  logic [5:0]  o_sec;
  logic        o_edit;
  logic [2:0]  o_field;
  logic        o_blink;

  always #5 clk = ~clk;

  rtc_calendar_set #(
    .CNT1MS     (10),
    .DEBOUNCE_MS(2),
    .BLINK_MS   (3)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tick1s    (tick1s),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_up    (btn_up),
    .year      (o_year),
    .month     (o_month),
    .day       (o_day),
    .hour      (o_hour),
    .min       (o_min),
    .sec       (o_sec),
    .edit_mode (o_edit),
    .edit_field(o_field),
    .blink     (o_blink)
  );

  typedef struct packed {
    logic [11:0] y;
    logic [3:0]  mo;
    logic [4:0]  d;
    logic [4:0]  h;
    logic [5:0]  mi;
    logic [5:0]  s;
    logic        e;
    logic [2:0]  f;
    logic        b;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc_cnt = 0;
  bit    mon_en = 1'b0;

  int m_y, m_mo, m_d, m_h, m_mi, m_s, m_f;
  bit m_e;

  function automatic int dim(int y, int mo);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && y % 4 == 0) return 29;
    return t[mo-1];
  endfunction

  function automatic void model_reset();
    m_y = 2024; m_mo = 1; m_d = 1;
    m_h = 0; m_mi = 0; m_s = 0;
    m_e = 1'b0; m_f = 0;
  endfunction

  function automatic void model_tick();
    int t;
    t = m_h * 3600 + m_mi * 60 + m_s + 1;
    if (t == 86400) begin
      t = 0;
      m_d++;
      if (m_d > dim(m_y, m_mo)) begin
        m_d = 1;
        m_mo++;
        if (m_mo > 12) begin
          m_mo = 1;
          m_y = 2000 + (m_y - 2000 + 1) % 100;
        end
      end
    end
    m_h = t / 3600;
    m_mi = (t / 60) % 60;
    m_s = t % 60;
  endfunction

  function automatic void model_up();
    case (m_f)
      0: m_y = 2000 + (m_y - 2000 + 1) % 100;
      1: m_mo = m_mo % 12 + 1;
      2: m_d = m_d % dim(m_y, m_mo) + 1;
      3: m_h = (m_h + 1) % 24;
      4: m_mi = (m_mi + 1) % 60;
      default: m_s = (m_s + 1) % 60;
    endcase
    if (m_d > dim(m_y, m_mo)) m_d = dim(m_y, m_mo);
  endfunction

  function automatic void model_press(bit m, bit n, bit u);
    if (m) begin
      m_e = !m_e;
      if (m_e) m_f = 0;
    end else if (m_e && n) begin
      m_f = (m_f + 1) % 6;
    end else if (m_e && u) begin
      model_up();
    end
  endfunction

  function automatic int field_val(int f);
    case (f)
      0: return m_y;
      1: return m_mo;
      2: return m_d;
      3: return m_h;
      4: return m_mi;
      default: return m_s;
    endcase
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.y = 12'(m_y); s.mo = 4'(m_mo); s.d = 5'(m_d);
    s.h = 5'(m_h); s.mi = 6'(m_mi); s.s = 6'(m_s);
    s.e = m_e; s.f = 3'(m_f); s.b = 1'b1;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.y = o_year; s.mo = o_month; s.d = o_day;
    s.h = o_hour; s.mi = o_min; s.s = o_sec;
    s.e = o_edit; s.f = o_field; s.b = o_blink;
    return s;
  endfunction

  function automatic snap_t nob(snap_t s);
    s.b = 1'b0;
    return s;
  endfunction

  function automatic bit snap_ok(snap_t ex, snap_t act);
    if (nob(ex) !== nob(act)) return 1'b0;
    if (!ex.e && act.b !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("%0d/%0d/%0d %0d:%0d:%0d edit=%0d fld=%0d blink=%0d",
                     s.y, s.mo, s.d, s.h, s.mi, s.s, s.e, s.f, s.b);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc_cnt++;
    end
  end

  // monitor: every visible change of the calendar/cursor state pops one expectation
  initial begin
    snap_t prev, cur, ex;
    bit pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pv = 1'b0;
      end else begin
        cur = dut_snap();
        if (!pv) begin
          prev = cur;
          pv = 1'b1;
        end else if (nob(cur) !== nob(prev)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got %s want no change", fmt(cur));
          end else begin
            ex = exp_q.pop_front();
            if (!snap_ok(ex, cur)) begin
              errors++;
              $display("FAIL scoreboard got %s want %s", fmt(cur), fmt(ex));
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got pending=%0d want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_now(string nm);
    snap_t ex, act;
    ex = model_snap();
    act = dut_snap();
    checks++;
    if (!snap_ok(ex, act)) begin
      errors++;
      $display("FAIL %s got %s want %s", nm, fmt(act), fmt(ex));
    end
  endtask

  task automatic tick();
    if (!m_e) begin
      model_tick();
      exp_q.push_back(model_snap());
    end
    tick1s = 1'b1;
    cyc(1);
    tick1s = 1'b0;
    cyc(2);
    drain("tick");
  endtask

  task automatic set_btns(bit m, bit n, bit u);
    btn_mode = m;
    btn_next = n;
    btn_up = u;
  endtask

  task automatic press(bit m, bit n, bit u);
    snap_t b4;
    b4 = model_snap();
    model_press(m, n, u);
    if (model_snap() != b4) exp_q.push_back(model_snap());
    repeat ($urandom_range(0, 1)) begin
      set_btns(m, n, u);
      cyc($urandom_range(1, 4));
      set_btns(0, 0, 0);
      cyc($urandom_range(1, 4));
    end
    set_btns(m, n, u);
    cyc(30);
    set_btns(0, 0, 0);
    cyc(25);
    drain("press");
  endtask

  task automatic set_field(int f, int tgt);
    while (m_f != f) press(0, 1, 0);
    while (field_val(f) != tgt) press(0, 0, 1);
  endtask

  task automatic set_all(int y, int mo, int d, int h, int mi, int s);
    set_field(0, y);
    set_field(1, mo);
    set_field(2, d);
    set_field(3, h);
    set_field(4, mi);
    set_field(5, s);
  endtask

  task automatic wait_blink(output int at, output bit ok);
    logic b0;
    int n;
    b0 = o_blink;
    n = 0;
    while (o_blink == b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (o_blink != b0);
    at = cyc_cnt;
  endtask

  task automatic blink_check();
    int t0, t1, t2;
    bit k0, k1, k2;
    wait_blink(t0, k0);
    wait_blink(t1, k1);
    wait_blink(t2, k2);
    checks++;
    if (!(k0 && k1 && k2)) begin
      errors++;
      $display("FAIL blink_edges got timeout want toggling");
    end else begin
      checks++;
      if (t1 - t0 != 30 || t2 - t1 != 30) begin
        errors++;
        $display("FAIL blink_period got %0d,%0d want 30,30", t1 - t0, t2 - t1);
      end
    end
  endtask

  initial begin
    model_reset();
    cyc(3);
    resetn = 1'b1;
    cyc(2);
    check_now("reset");
    mon_en = 1'b1;
    cyc(3);

    repeat ($urandom_range(3, 8)) tick();
    check_now("run_state");

    press(1, 0, 0);
    check_now("enter_edit");
    tick();
    tick();
    check_now("tick_ignored");
    blink_check();

    press(0, 1, 0);
    press(0, 1, 0);
    repeat (2) begin
      btn_up = 1'b1;
      cyc(10);
      btn_up = 1'b0;
      cyc(30);
    end
    check_now("glitch_ignored");
    press(0, 0, 1);
    cyc(40);
    check_now("no_release_inc");

    set_field(2, 31);
    press(0, 0, 1);
    check_now("day_wrap");
    set_field(2, 31);
    repeat (4) press(0, 1, 0);
    check_now("field_wrap");
    press(0, 1, 0);
    press(0, 0, 1);
    check_now("clamp_leap");

    repeat (10) begin
      if ($urandom_range(0, 1) == 1 || m_f == 0) press(0, 1, 0);
      else press(0, 0, 1);
    end

    set_all(2024, 2, 28, 23, 59, 59);
    press(1, 0, 0);
    check_now("run_blink");
    tick();
    check_now("leap_feb29");

    press(1, 0, 0);
    set_all(2023, 2, 28, 23, 59, 59);
    press(1, 0, 0);
    tick();
    check_now("feb28_2023");

    press(1, 0, 0);
    set_all(2099, 12, 31, 23, 59, 59);
    press(1, 0, 0);
    tick();
    check_now("year_wrap");

    press(1, 0, 0);
    press(0, 1, 1);
    check_now("prio_next_up");
    press(1, 0, 1);
    check_now("prio_mode_up");
    repeat ($urandom_range(2, 5)) tick();
    check_now("run_resume");

    btn_up = 1'b1;
    cyc(8);
    if (model_snap() != '{12'd2024, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, 1'b0, 3'd0, 1'b1}) begin
      model_reset();
      exp_q.push_back(model_snap());
    end else begin
      model_reset();
    end
    resetn = 1'b0;
    btn_up = 1'b0;
    cyc(5);
    resetn = 1'b1;
    cyc(3);
    drain("mid_reset");
    check_now("mid_reset");

    cyc(20);
    drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
